mirfak_multiplier_pipe: RTL and testbench

- Parametrised pipelined integer multiplier for the Mirfak execute stage. Implements RV32M MUL/MULH/MULHSU/MULHU at configurable width and pipeline depth.
- Adds a single-entry product cache. A back-to-back MULH*/MUL pair on the same operands completes in one cycle instead of the full pipeline latency.
- Sits beside the ALU and is driven by the same enable/abort/ack handshake as the other execute-stage units.

---
 rtl/mirfak_multiplier_pipe.sv | 144 ++++++++++++++
 tb/tb_mirfak_multiplier_pipe.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mirfak_multiplier_pipe.sv
// Pipelined RV32M-style multiplier (MUL/MULH/MULHSU/MULHU) for the Mirfak execute stage.
// A single-entry product cache lets a repeat operation on the same operands finish in one cycle.
module mirfak_multiplier_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STAGES     = 2,
  parameter bit          FAST_REUSE = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] mult_op1,
  input  logic [XLEN-1:0] mult_op2,
  input  logic [1:0]      mult_cmd,
  input  logic            mult_enable,
  input  logic            mult_abort,
  output logic [XLEN-1:0] mult_result,
  output logic            mult_ack
);

  localparam int unsigned CntW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STAGES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // {op1 signed, op2 signed}
  function automatic logic [1:0] sign_class(input logic [1:0] cmd);
    return {(cmd == 2'b01) || (cmd == 2'b10), cmd == 2'b01};
  endfunction

  state_e              r_state, w_state_nxt;
  logic [CntW-1:0]     r_cnt;
  logic [XLEN-1:0]     r_op1, r_op2, r_result;
  logic [1:0]          r_cmd;
  logic                r_c_valid;
  logic [XLEN-1:0]     r_c_op1, r_c_op2;
  logic [1:0]          r_c_cls;
  logic [2*XLEN-1:0]   r_c_prod;

  logic [1:0]          w_cls;
  logic [2*XLEN-1:0]   w_a, w_b, w_prod, w_prod_out;
  logic [XLEN-1:0]     w_busy_res, w_cache_res;
  logic                w_hit, w_last, w_capture, w_load_hit, w_load_miss;

  // Extending to the full product width keeps the low 2*XLEN bits of the signed product exact.
  assign w_cls  = sign_class(r_cmd);
  assign w_a    = {{XLEN{w_cls[1] & r_op1[XLEN-1]}}, r_op1};
  assign w_b    = {{XLEN{w_cls[0] & r_op2[XLEN-1]}}, r_op2};
  assign w_prod = w_a * w_b;

  if (STAGES > 1) begin : g_pipe
    logic [2*XLEN-1:0] r_pipe [STAGES-1];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(STAGES) - 1; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_prod;
        for (int i = 1; i < int'(STAGES) - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign w_prod_out = r_pipe[STAGES-2];
  end else begin : g_nopipe
    assign w_prod_out = w_prod;
  end

  assign w_busy_res  = (r_cmd == 2'b00) ? w_prod_out[XLEN-1:0] : w_prod_out[2*XLEN-1:XLEN];
  assign w_cache_res = (mult_cmd == 2'b00) ? r_c_prod[XLEN-1:0] : r_c_prod[2*XLEN-1:XLEN];

  // The low half is identical for every signedness, so MUL hits regardless of class.
  assign w_hit = FAST_REUSE && r_c_valid && (mult_op1 == r_c_op1) && (mult_op2 == r_c_op2) &&
                 ((mult_cmd == 2'b00) || (sign_class(mult_cmd) == r_c_cls));
  assign w_last = (r_cnt == CntMax);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load_hit  = 1'b0;
    w_load_miss = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (mult_abort) begin
          w_state_nxt = StIdle;
        end else if (mult_enable && w_hit) begin
          w_state_nxt = StDone;
          w_load_hit  = 1'b1;
        end else if (mult_enable) begin
          w_state_nxt = StBusy;
          w_capture   = 1'b1;
        end
      end
      StBusy: begin
        if (mult_abort) begin
          w_state_nxt = StIdle;
        end else if (w_last) begin
          w_state_nxt = StDone;
          w_load_miss = 1'b1;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_cmd    <= 2'b00;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_op1 <= mult_op1;
        r_op2 <= mult_op2;
        r_cmd <= mult_cmd;
        r_cnt <= '0;
      end else if (r_state == StBusy && !w_last) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_load_hit)       r_result <= w_cache_res;
      else if (w_load_miss) r_result <= w_busy_res;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_c_valid <= 1'b0;
      r_c_op1   <= '0;
      r_c_op2   <= '0;
      r_c_cls   <= 2'b00;
      r_c_prod  <= '0;
    end else if (FAST_REUSE && w_load_miss) begin
      r_c_valid <= 1'b1;
      r_c_op1   <= r_op1;
      r_c_op2   <= r_op2;
      r_c_cls   <= w_cls;
      r_c_prod  <= w_prod_out;
    end
  end

  assign mult_result = r_result;
  assign mult_ack    = (r_state == StDone) && !mult_abort;

endmodule

// File: tb/tb_mirfak_multiplier_pipe.sv
// Directed bench: unit 0 is XLEN=32/STAGES=2 with reuse, unit 1 is STAGES=4 without reuse.
module tb_mirfak_multiplier_pipe;

  logic        clk, rst;
  logic [31:0] a0, b0, a1, b1, res0, res1;
  logic [1:0]  c0, c1;
  logic        en0, ab0, ack0, en1, ab1, ack1;
  int          checks = 0;
  int          errors = 0;

  mirfak_multiplier_pipe #(.XLEN(32), .STAGES(2), .FAST_REUSE(1'b1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .mult_op1(a0), .mult_op2(b0), .mult_cmd(c0),
    .mult_enable(en0), .mult_abort(ab0), .mult_result(res0), .mult_ack(ack0)
  );

  mirfak_multiplier_pipe #(.XLEN(32), .STAGES(4), .FAST_REUSE(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .mult_op1(a1), .mult_op2(b1), .mult_cmd(c1),
    .mult_enable(en1), .mult_abort(ab1), .mult_result(res1), .mult_ack(ack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic en, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] c);
    if (u == 0) begin en0 = en; a0 = a; b0 = b; c0 = c; end
    else        begin en1 = en; a1 = a; b1 = b; c1 = c; end
  endtask

  function automatic logic get_ack(input int u);
    return (u == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [31:0] get_res(input int u);
    return (u == 0) ? res0 : res1;
  endfunction

  // exp_lat = edges after the enable-sampling edge T before ack is seen (0 = hit).
  task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input int exp_lat, input logic [31:0] exp_res,
                        input string tag);
    int lat;
    lat = -1;
    drive(u, 1'b1, a, b, c);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (get_ack(u)) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(get_res(u)), 64'(exp_res));
    @(posedge clk); #1;
    drive(u, 1'b0, a, b, c);
    check({tag, " ack drop"}, 64'(get_ack(u)), 64'd0);
    check({tag, " result hold"}, 64'(get_res(u)), 64'(exp_res));
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    ab0 = 1'b0;
    ab1 = 1'b0;
    drive(0, 1'b0, 32'd0, 32'd0, 2'b00);
    drive(1, 1'b0, 32'd0, 32'd0, 2'b00);
    #1;
    check("reset ack0", 64'(ack0), 64'd0);
    check("reset res0", 64'(res0), 64'd0);
    check("reset ack1", 64'(ack1), 64'd0);
    check("reset res1", 64'(res1), 64'd0);
    #11 rst = 1'b0;

    run_op(0, 32'd7, 32'd6, 2'b00, 2, 32'h0000_002A, "mul 7x6");

    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 2, 32'h0000_0000, "mulh -1x-1");
    run_op(0, 32'd1, 32'd1, 2'b00, 2, 32'h0000_0001, "mul 1x1 a");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 2, 32'hFFFF_FFFE, "mulhu ff");
    run_op(0, 32'd1, 32'd1, 2'b00, 2, 32'h0000_0001, "mul 1x1 b");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2, 32'hFFFF_FFFF, "mulhsu ff");

    run_op(0, 32'h0001_0000, 32'h0001_0000, 2'b11, 2, 32'h0000_0001, "reuse mulhu");
    run_op(0, 32'h0001_0000, 32'h0001_0000, 2'b00, 0, 32'h0000_0000, "reuse mul hit");
    run_op(0, 32'h0001_0000, 32'h0001_0000, 2'b01, 2, 32'h0000_0001, "reuse mulh miss");

    // Abort while idle with enable high: nothing starts.
    drive(0, 1'b1, 32'd3, 32'd5, 2'b00);
    ab0 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      seen |= ack0;
    end
    ab0 = 1'b0;
    drive(0, 1'b0, 32'd3, 32'd5, 2'b00);
    check("abort idle no ack", 64'(seen), 64'd0);

    // Abort one cycle into BUSY.
    drive(0, 1'b1, 32'd3, 32'd5, 2'b00);
    @(posedge clk); #1;
    ab0 = 1'b1;
    @(posedge clk); #1;
    ab0 = 1'b0;
    drive(0, 1'b0, 32'd3, 32'd5, 2'b00);
    seen = ack0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      seen |= ack0;
    end
    check("abort busy no ack", 64'(seen), 64'd0);
    check("abort result kept", 64'(res0), 64'h0000_0001);
    run_op(0, 32'h0001_0000, 32'h0001_0000, 2'b01, 0, 32'h0000_0001, "cache kept hit");
    run_op(0, 32'd3, 32'd5, 2'b00, 2, 32'h0000_000F, "mul 3x5 after abort");

    // Async reset in the middle of a BUSY cycle.
    drive(0, 1'b1, 32'd9, 32'd9, 2'b00);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async rst ack", 64'(ack0), 64'd0);
    check("async rst result", 64'(res0), 64'd0);
    drive(0, 1'b0, 32'd9, 32'd9, 2'b00);
    #2 rst = 1'b0;
    run_op(0, 32'd2, 32'd2, 2'b00, 2, 32'h0000_0004, "mul 2x2 post rst");
    run_op(0, 32'h0001_0000, 32'h0001_0000, 2'b01, 2, 32'h0000_0001, "cache cleared");

    run_op(1, 32'h8000_0000, 32'd2, 2'b00, 4, 32'h0000_0000, "s4 mul a");
    run_op(1, 32'h8000_0000, 32'd2, 2'b00, 4, 32'h0000_0000, "s4 mul repeat");
    run_op(1, 32'h8000_0000, 32'd2, 2'b11, 4, 32'h0000_0001, "s4 mulhu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
